// File: rtl/bcd_scan_pkg.sv
// Shared definitions for the BCD digit scan controller: widths, FSM states, code check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bcd_scan_pkg;

    localparam int BCD_W = 4;
    localparam int DEC_W = 9;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // A 4-bit code above 9 is not a decimal digit
    function automatic logic code_invalid(input logic [BCD_W-1:0] code);
        return code > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_dwell_cnt.sv
// Loadable down-counter that times how long a digit stays strobed.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; stops at zero until reloaded.
module bcd_dwell_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; the count saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Scans NUM_DIGITS shadowed BCD digits through one external decoder and strobes them in turn.
// Latency: 1 SETUP cycle + DWELL HOLD cycles per digit; decoded pattern registered at SETUP->HOLD.
// Backpressure: none; en low drops to IDLE next cycle. BCD_SCAN_BLANK_EN enables leading-zero blanking.
module bcd_scan_ctrl
    import bcd_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 4,
    parameter int IDX_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    output logic [BCD_W-1:0]            dec_a,
    input  logic [DEC_W-1:0]            dec_b,
    output logic [NUM_DIGITS-1:0]       dig_sel,
    output logic [DEC_W-1:0]            dig_val,
    output logic                        frame_done,
    output logic                        err
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t                               state;
    state_t                               state_nxt;
    logic [IDX_W-1:0]                     idx;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]     shadow;
    logic [BCD_W-1:0]                     cur_code;
    logic [BCD_W-1:0]                     hold_code;
    logic                                 hold_blank;
    logic                                 blank_now;
    logic                                 cnt_zero;
    logic                                 last_digit;
    logic                                 slot_end;
    logic                                 capture;

    assign cur_code   = shadow[idx];
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign slot_end   = (state == HOLD) && cnt_zero;
    // The SETUP->HOLD edge: latch the decoder result and what was presented
    assign capture    = (state == SETUP) && en;

    bcd_dwell_cnt #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (state == SETUP),
        .load_val (CNT_W'(DWELL - 1)),
        .dec      (state == HOLD),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: en low overrides everything and parks the scan in IDLE
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SETUP;
                SETUP:   state_nxt = HOLD;
                HOLD:    state_nxt = cnt_zero ? SETUP : HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs: decoder fed in SETUP and HOLD, strobe and frame pulse only in HOLD
    always_comb begin
        dec_a      = '0;
        dig_sel    = '0;
        frame_done = 1'b0;
        case (state)
            SETUP: begin
                dec_a = cur_code;
            end
            HOLD: begin
                dec_a = hold_code;
                if (!hold_blank) begin
                    dig_sel = NUM_DIGITS'(1) << idx;
                end
                frame_done = cnt_zero && last_digit;
            end
            default: begin
            end
        endcase
    end

    // Digit index: restart at 0 whenever the scan is disabled, advance at slot end
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            idx <= '0;
        end else if (slot_end) begin
            idx <= last_digit ? '0 : idx + 1'b1;
        end
    end

    // Shadow register; the next SETUP sees freshly loaded digits
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= digits_in;
        end
    end

    // Capture at SETUP->HOLD so a load during HOLD cannot tear the shown digit
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_val    <= '0;
            hold_code  <= '0;
            hold_blank <= 1'b0;
            err        <= 1'b0;
        end else if (capture) begin
            dig_val    <= dec_b;
            hold_code  <= cur_code;
            hold_blank <= blank_now;
            if (code_invalid(cur_code)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef BCD_SCAN_BLANK_EN
    // Blank a non-zero-index digit when it and every more significant digit are zero
    always_comb begin
        blank_now = (idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx) && (shadow[i] != '0)) begin
                blank_now = 1'b0;
            end
        end
    end
`else
    assign blank_now = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
module tb_bcd_scan_ctrl;
    import bcd_scan_pkg::*;

    localparam int N = 4;
    localparam int D = 4;
    localparam int FRAME = N * (D + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [4*N-1:0]   digits_in;
    logic [3:0]       dec_a;
    logic [8:0]       dec_b;
    logic [N-1:0]     dig_sel;
    logic [8:0]       dig_val;
    logic             frame_done;
    logic             err;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: position within the scan rather than an FSM
    bit         m_active;
    int         m_p;
    logic [3:0] m_sh [N];
    logic [8:0] m_val;
    logic       m_err;
    logic [3:0] m_code;
    bit         m_blank;

    always #5 clk = ~clk;

    function automatic logic [8:0] decode(input logic [3:0] a);
        if (a >= 4'd1 && a <= 4'd9) return 9'(1) << (a - 4'd1);
        return 9'd0;
    endfunction

    // External shared decoder
    assign dec_b = decode(dec_a);

    bcd_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .IDX_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .dec_a      (dec_a),
        .dec_b      (dec_b),
        .dig_sel    (dig_sel),
        .dig_val    (dig_val),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit blank_of(input int dgt);
`ifdef BCD_SCAN_BLANK_EN
        if (dgt == 0) return 1'b0;
        for (int j = dgt; j < N; j++) if (m_sh[j] != 4'd0) return 1'b0;
        return 1'b1;
`else
        return (dgt < 0);
`endif
    endfunction

    task automatic model_edge();
        int dgt;
        int ph;
        if (rst) begin
            m_active = 0; m_p = 0;
            for (int i = 0; i < N; i++) m_sh[i] = 4'd0;
            m_val = '0; m_err = 1'b0; m_code = '0; m_blank = 0;
        end else begin
            if (m_active && en) begin
                ph  = m_p % (D + 1);
                dgt = (m_p / (D + 1)) % N;
                if (ph == 0) begin
                    m_val   = decode(m_sh[dgt]);
                    m_code  = m_sh[dgt];
                    m_blank = blank_of(dgt);
                    if (m_sh[dgt] > 4'd9) m_err = 1'b1;
                end
            end
            if (!en) begin
                m_active = 0; m_p = 0;
            end else if (!m_active) begin
                m_active = 1; m_p = 0;
            end else begin
                m_p++;
            end
            if (load) for (int i = 0; i < N; i++) m_sh[i] = digits_in[4*i +: 4];
        end
    endtask

    task automatic check_outputs();
        logic [3:0]   e_a;
        logic [N-1:0] e_sel;
        logic         e_fd;
        int ph;
        int dgt;
        e_a = '0; e_sel = '0; e_fd = 1'b0;
        if (m_active) begin
            ph  = m_p % (D + 1);
            dgt = (m_p / (D + 1)) % N;
            if (ph == 0) begin
                e_a = m_sh[dgt];
            end else begin
                e_a = m_code;
                if (!m_blank) e_sel = N'(1) << dgt;
                e_fd = (ph == D) && (dgt == N - 1);
            end
        end
        chk("dec_a", 32'(dec_a), 32'(e_a));
        chk("dig_sel", 32'(dig_sel), 32'(e_sel));
        chk("dig_val", 32'(dig_val), 32'(m_val));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_sel(input logic [N-1:0] m);
        int k = 0;
        while (dig_sel !== m && k < 200) begin
            cyc();
            k++;
        end
        chk("wait_sel", 32'(dig_sel), 32'(m));
    endtask

    initial begin
        int fd_cyc;
        int fd_cnt;
        int c;
        logic [8:0] seen_val [N];
        int strobes [N];
        logic [N-1:0] sel_seen;
        logic [8:0] saved;
        logic [3:0] nib;

        rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0;
        m_active = 0; m_p = 0; m_val = '0; m_err = 1'b0; m_code = '0; m_blank = 0;
        for (int i = 0; i < N; i++) m_sh[i] = 4'd0;
        cyc(); cyc();
        chk("rst_dec_a", 32'(dec_a), 0);
        chk("rst_dig_val", 32'(dig_val), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;

        // Basic frame with 0x4321
        load = 1'b1; digits_in = 16'h4321;
        cyc();
        load = 1'b0; en = 1'b1;
        fd_cyc = 0;
        for (int i = 0; i < N; i++) begin seen_val[i] = '0; strobes[i] = 0; end
        for (int k = 1; k <= FRAME; k++) begin
            cyc();
            if (frame_done && fd_cyc == 0) fd_cyc = k;
            for (int i = 0; i < N; i++) if (dig_sel[i]) begin seen_val[i] = dig_val; strobes[i]++; end
        end
        chk("frame_done_cyc", 32'(fd_cyc), 32'(FRAME));
        for (int i = 0; i < N; i++) begin
            chk("digit_val", 32'(seen_val[i]), 32'(9'(1) << i));
            chk("digit_strobes", 32'(strobes[i]), 32'(D));
        end

        // Reset for 3 cycles in the middle of a HOLD
        wait_sel(4'b0010);
        rst = 1'b1;
        cyc();
        chk("midrst_sel", 32'(dig_sel), 0);
        chk("midrst_val", 32'(dig_val), 0);
        chk("midrst_dec_a", 32'(dec_a), 0);
        cyc(); cyc();
        rst = 1'b0;

        // Invalid code sets sticky err
        load = 1'b1; digits_in = 16'h0B05;
        cyc();
        load = 1'b0;
        repeat (2 * FRAME) cyc();
        chk("err_set", 32'(err), 1);
        load = 1'b1; digits_in = 16'h1111;
        cyc();
        load = 1'b0;
        repeat (FRAME) cyc();
        chk("err_sticky", 32'(err), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("err_clr", 32'(err), 0);
        load = 1'b1; digits_in = 16'h1234;
        cyc();
        load = 1'b0;

        // Load during HOLD of digit 1: no tearing, next SETUP shows new code
        wait_sel(4'b0010);
        saved = dig_val;
        load = 1'b1; digits_in = 16'h5678;
        cyc();
        load = 1'b0;
        c = 0;
        while (dig_sel === 4'b0010 && c < 10) begin
            chk("no_tear", 32'(dig_val), 32'(saved));
            cyc();
            c++;
        end
        chk("setup_sel", 32'(dig_sel), 0);
        chk("setup_new_code", 32'(dec_a), 32'h6);

        // Drop en during HOLD of digit 2, then restart
        wait_sel(4'b0100);
        en = 1'b0;
        cyc();
        chk("endrop_sel", 32'(dig_sel), 0);
        chk("endrop_dec_a", 32'(dec_a), 0);
        cyc();
        en = 1'b1;
        c = 0;
        do begin
            cyc();
            c++;
        end while (!frame_done && c < 3 * FRAME);
        chk("restart_fd_cyc", 32'(c), 32'(FRAME));

`ifdef BCD_SCAN_BLANK_EN
        en = 1'b0; load = 1'b1; digits_in = 16'h0070;
        cyc();
        load = 1'b0; en = 1'b1;
        sel_seen = '0; fd_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cyc();
            sel_seen |= dig_sel;
            if (frame_done) fd_cnt++;
        end
        chk("blank_sel_seen", 32'(sel_seen), 32'h3);
        chk("blank_fd_cnt", 32'(fd_cnt), 2);
`else
        sel_seen = '0; fd_cnt = 0;
`endif

        // Randomized traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom % 200) == 0;
            en   = ($urandom % 40) != 0;
            load = ($urandom % 8) == 0;
            for (int i = 0; i < N; i++) begin
                case ($urandom % 6)
                    0, 1:    nib = 4'd0;
                    2:       nib = 4'($urandom_range(10, 15));
                    default: nib = 4'($urandom_range(1, 9));
                endcase
                digits_in[4*i +: 4] = nib;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
